// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding and
// the funct3 access-width codes.
package lsu_pkg;

  localparam int unsigned Xlen = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  function automatic logic width_supported(logic [2:0] w);
    return (w == F3Lb) || (w == F3Lh) || (w == F3Lw) || (w == F3Lbu) || (w == F3Lhu);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU signal bundle: upstream instruction handshake, WBU result handshake and
// the word-oriented memory bus.
interface lsu_if;

  logic                     in_valid;
  logic                     in_ready;
  logic                     mem_en;
  logic                     mem_wen;
  logic [2:0]               mem_width;
  logic [lsu_pkg::Xlen-1:0] addr;
  logic [lsu_pkg::Xlen-1:0] wdata;

  logic                     out_valid;
  logic                     out_ready;
  logic [lsu_pkg::Xlen-1:0] ld_data;
  logic                     err;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_wen;
  logic [lsu_pkg::Xlen-1:0] req_addr;
  logic [lsu_pkg::Xlen-1:0] req_wdata;
  logic [3:0]               req_wmask;
  logic                     resp_valid;
  logic [lsu_pkg::Xlen-1:0] resp_rdata;
  logic                     resp_err;

  // LSU side.
  modport slave (
    input  in_valid, mem_en, mem_wen, mem_width, addr, wdata, out_ready,
           req_ready, resp_valid, resp_rdata, resp_err,
    output in_ready, out_valid, ld_data, err,
           req_valid, req_wen, req_addr, req_wdata, req_wmask
  );

  // Environment side (EXU, WBU and memory).
  modport master (
    output in_valid, mem_en, mem_wen, mem_width, addr, wdata, out_ready,
           req_ready, resp_valid, resp_rdata, resp_err,
    input  in_ready, out_valid, ld_data, err,
           req_valid, req_wen, req_addr, req_wdata, req_wmask
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational store lane alignment and load extraction/extension.
// LSU_MISALIGN_CHECK_EN enables the misaligned-access flag.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [1:0]  hoff;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords always use the naturally aligned lane containing the offset.
  assign hoff = {off_i[1], 1'b0};

  always_comb begin
    wmask_o = 4'b0000;
    wdata_o = 32'h0;
    unique case (width_i[1:0])
      2'b00: begin
        wmask_o = 4'b0001 << off_i;
        wdata_o = {24'h0, wdata_i[7:0]} << {off_i, 3'b000};
      end
      2'b01: begin
        wmask_o = 4'b0011 << hoff;
        wdata_o = {16'h0, wdata_i[15:0]} << {hoff, 3'b000};
      end
      2'b10: begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        wmask_o = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_lane = rdata_i[7:0];
    unique case (off_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase
  end

  assign half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    ld_data_o = 32'h0;
    case (width_i)
      F3Lb:    ld_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3Lbu:   ld_data_o = {24'h0, byte_lane};
      F3Lh:    ld_data_o = {{16{half_lane[15]}}, half_lane};
      F3Lhu:   ld_data_o = {16'h0, half_lane};
      F3Lw:    ld_data_o = rdata_i;
      default: ld_data_o = 32'h0;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_o = ((width_i[1:0] == 2'b01) && off_i[0]) ||
                      ((width_i[1:0] == 2'b10) && (off_i != 2'b00));
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EXU instruction at a time, performs a single
// word bus transaction and returns the result to WBU. LSU_MISALIGN_CHECK_EN
// turns misaligned accesses into access faults.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  lsu_state_e state_q, state_d;

  logic            wen_q, wen_d;
  logic [2:0]      width_q, width_d;
  logic [1:0]      off_q, off_d;
  logic            req_valid_q, req_valid_d;
  logic            req_wen_q, req_wen_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]      req_wmask_q, req_wmask_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            err_q, err_d;

  logic [2:0]  al_width;
  logic [1:0]  al_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;
  logic        al_misalign;

  // In IDLE the aligner sees the incoming instruction; afterwards the captured one.
  assign al_width = (state_q == StIdle) ? bus.mem_width : width_q;
  assign al_off   = (state_q == StIdle) ? bus.addr[1:0] : off_q;

  lsu_align u_align (
    .width_i    (al_width),
    .off_i      (al_off),
    .wdata_i    (bus.wdata),
    .rdata_i    (bus.resp_rdata),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld_data),
    .misalign_o (al_misalign)
  );

  assign bus.in_ready = (state_q == StIdle) && !rst;

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    width_d     = width_q;
    off_d       = off_q;
    req_valid_d = req_valid_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    out_valid_d = out_valid_q;
    ld_data_d   = ld_data_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          wen_d   = bus.mem_wen;
          width_d = bus.mem_width;
          off_d   = bus.addr[1:0];
          if (!bus.mem_en) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            ld_data_d   = '0;
            err_d       = 1'b0;
          end else if (!width_supported(bus.mem_width) || al_misalign) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            ld_data_d   = '0;
            err_d       = 1'b1;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            req_wen_d   = bus.mem_wen;
            req_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
            req_wdata_d = bus.mem_wen ? al_wdata : '0;
            req_wmask_d = bus.mem_wen ? al_wmask : 4'b0000;
          end
        end
      end
      StReq: begin
        if (bus.req_ready) begin
          state_d     = StWait;
          req_valid_d = 1'b0;
        end
      end
      StWait: begin
        if (bus.resp_valid) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          err_d       = bus.resp_err;
          ld_data_d   = (bus.resp_err || wen_q) ? '0 : al_ld_data;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wen_q       <= 1'b0;
      width_q     <= 3'b000;
      off_q       <= 2'b00;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= 4'b0000;
      out_valid_q <= 1'b0;
      ld_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      width_q     <= width_d;
      off_q       <= off_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      out_valid_q <= out_valid_d;
      ld_data_q   <= ld_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_wen   = req_wen_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_wmask = req_wmask_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.err       = err_q;

endmodule
